board_io_conditioner: RTL and testbench



---
 rtl/board_io_conditioner.sv | 168 ++++++++++++++++
 tb/tb_board_io_conditioner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_conditioner.sv
// board_io_conditioner
//
// Front end between the FPGA board pins and the pipelined core. It
// synchronises and debounces the switch and button pins, normalises button
// polarity so that 1 always means pressed, emits one-cycle press / release /
// switch-change pulses, and produces a stretched core reset from the board
// reset or from a core-side reset request.
//
// Ports:
//   clk_i          core clock, rising edge
//   rst_ni         synchronous active-low board reset
//   sw_i           raw switch pins (asynchronous)
//   btn_i          raw button pins (asynchronous)
//   rst_req_i      core-domain reset request, level sampled every cycle
//   sw_o           debounced switch levels
//   btn_o          debounced buttons, 1 = pressed
//   btn_press_o    one-cycle pulse when a debounced button becomes pressed
//   btn_release_o  one-cycle pulse when a debounced button is released
//   sw_change_o    one-cycle pulse when a debounced switch changes
//   rst_core_no    registered active-low core reset

module board_io_conditioner #(
  parameter int SW_WIDTH        = 10,
  parameter int BTN_WIDTH       = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD        = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [SW_WIDTH-1:0]  sw_i,
  input  logic [BTN_WIDTH-1:0] btn_i,
  input  logic                 rst_req_i,
  output logic [SW_WIDTH-1:0]  sw_o,
  output logic [BTN_WIDTH-1:0] btn_o,
  output logic [BTN_WIDTH-1:0] btn_press_o,
  output logic [BTN_WIDTH-1:0] btn_release_o,
  output logic [SW_WIDTH-1:0]  sw_change_o,
  output logic                 rst_core_no
);

  localparam int NCH = SW_WIDTH + BTN_WIDTH;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(RST_HOLD + 1);

  localparam logic [CW-1:0]        CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [BTN_WIDTH-1:0] BTN_IDLE  = BTN_ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0]  sw_sync;
  logic [SYNC_STAGES-1:0][BTN_WIDTH-1:0] btn_sync;
  logic [BTN_WIDTH-1:0]                  btn_norm;

  // Channel layout for the shared debouncer: switches in the low bits,
  // buttons (already polarity-normalised) in the high bits.
  logic [NCH-1:0]         samp;
  logic [NCH-1:0]         q;
  logic [NCH-1:0]         q_next;
  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0][CW-1:0] cnt_next;
  logic [NCH-1:0]         q_rise;
  logic [NCH-1:0]         q_fall;
  logic                   pulse_en;

  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_sync[SYNC_STAGES-1] : btn_sync[SYNC_STAGES-1];

  // Debounce decision per channel. A channel only moves to the sampled level
  // after DEBOUNCE_CYCLES consecutive mismatching cycles; any agreement in
  // between clears the run, so glitches never reach q.
  always_comb begin
    q_next   = q;
    cnt_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (samp[i] != q[i]) begin
        if (cnt[i] == CNT_LAST) begin
          q_next[i] = samp[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign q_rise = q_next & ~q;
  assign q_fall = ~q_next & q;

  // Pulses are registered with the q update. Gating on RUN at the edge
  // means a pulse can only appear in a cycle where rst_core_no is high,
  // because rst_core_no is registered from the same state.
  assign pulse_en = (state == RUN);

  // Input pipeline: synchroniser, then a registered normalised sample that
  // feeds the compare stage, then the stable level and pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sw_sync       <= '0;
      btn_sync      <= {SYNC_STAGES{BTN_IDLE}};
      samp          <= '0;
      q             <= '0;
      cnt           <= '0;
      sw_change_o   <= '0;
      btn_press_o   <= '0;
      btn_release_o <= '0;
    end else begin
      sw_sync       <= {sw_sync[SYNC_STAGES-2:0], sw_i};
      btn_sync      <= {btn_sync[SYNC_STAGES-2:0], btn_i};
      samp          <= {btn_norm, sw_sync[SYNC_STAGES-1]};
      q             <= q_next;
      cnt           <= cnt_next;
      sw_change_o   <= pulse_en ? (q_next[SW_WIDTH-1:0] ^ q[SW_WIDTH-1:0]) : '0;
      btn_press_o   <= pulse_en ? q_rise[NCH-1:SW_WIDTH] : '0;
      btn_release_o <= pulse_en ? q_fall[NCH-1:SW_WIDTH] : '0;
    end
  end

  assign sw_o  = q[SW_WIDTH-1:0];
  assign btn_o = q[NCH-1:SW_WIDTH];

  // Core reset sequencer. rst_core_no follows "state was RUN" one edge late,
  // so a request sampled in RUN drops the core reset on the following edge
  // and a hold of RST_HOLD cycles releases it RST_HOLD+1 edges after entry.
  // A request while holding restarts the hold count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= RESET;
      hold_cnt    <= '0;
      rst_core_no <= 1'b0;
    end else begin
      rst_core_no <= (state == RUN);
      case (state)
        RESET: begin
          state    <= HOLD;
          hold_cnt <= '0;
        end
        HOLD: begin
          if (rst_req_i) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= RUN;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          if (rst_req_i) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= RESET;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner
//
// Cycle-accurate bench for board_io_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, RST_HOLD=3, SW_WIDTH=2, BTN_WIDTH=2, active-low buttons.
// Each record holds the inputs for one rising edge and the outputs expected
// just after it; expectations go into a scoreboard queue when driven and are
// popped and compared 1 time unit after the edge.

module tb_board_io_conditioner;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n;
  logic       rst_req;
  logic [1:0] sw;
  logic [1:0] btn;
  logic [1:0] sw_o;
  logic [1:0] btn_o;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] sw_change;
  logic       rst_core_n;

  always #10 CLOCK_50 = ~CLOCK_50;

  board_io_conditioner #(
    .SW_WIDTH        (2),
    .BTN_WIDTH       (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD        (3),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i         (CLOCK_50),
    .rst_ni        (rst_n),
    .sw_i          (sw),
    .btn_i         (btn),
    .rst_req_i     (rst_req),
    .sw_o          (sw_o),
    .btn_o         (btn_o),
    .btn_press_o   (btn_press),
    .btn_release_o (btn_release),
    .sw_change_o   (sw_change),
    .rst_core_no   (rst_core_n)
  );

  typedef struct {
    logic       rst_n;
    logic       req;
    logic [1:0] sw;
    logic [1:0] btn;
    logic       e_rst;
    logic [1:0] e_sw;
    logic [1:0] e_btn;
    logic [1:0] e_press;
    logic [1:0] e_rel;
    logic [1:0] e_chg;
  } vec_t;

  vec_t  table_q[$];
  vec_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string phase = "init";

  function automatic vec_t mk(input logic r, input logic q, input logic [1:0] s,
                              input logic [1:0] b, input logic er,
                              input logic [1:0] es, input logic [1:0] eb,
                              input logic [1:0] ep, input logic [1:0] erl,
                              input logic [1:0] ec);
    vec_t v;
    v.rst_n   = r;
    v.req     = q;
    v.sw      = s;
    v.btn     = b;
    v.e_rst   = er;
    v.e_sw    = es;
    v.e_btn   = eb;
    v.e_press = ep;
    v.e_rel   = erl;
    v.e_chg   = ec;
    return v;
  endfunction

  task automatic add(input int n, input vec_t v);
    for (int i = 0; i < n; i++) table_q.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s cycle %0d: got %b, expected %b", phase, name, cyc, got, want);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard cycle %0d: got no entry, expected one", phase, cyc);
      return;
    end
    e = exp_q.pop_front();
    cmp("rst_core_no",   {1'b0, rst_core_n}, {1'b0, e.e_rst});
    cmp("sw_o",          sw_o,        e.e_sw);
    cmp("btn_o",         btn_o,       e.e_btn);
    cmp("btn_press_o",   btn_press,   e.e_press);
    cmp("btn_release_o", btn_release, e.e_rel);
    cmp("sw_change_o",   sw_change,   e.e_chg);
    cyc++;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLOCK_50);
    rst_n   = v.rst_n;
    rst_req = v.req;
    sw      = v.sw;
    btn     = v.btn;
    exp_q.push_back(v);
    @(posedge CLOCK_50);
    #1;
    checkOutput();
  endtask

  task automatic run(input int n, input vec_t v);
    for (int i = 0; i < n; i++) applyStimulus(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    rst_req = 1'b0;
    sw      = 2'b00;
    btn     = 2'b11;

    // Board reset, then release: core reset low after edges 0..3, high from 4.
    add(2, mk(0, 0, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(4, mk(1, 0, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(3, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // Clean press of button 0, visible 6 edges after the first sampling edge.
    add(6, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(1, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
    add(3, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    // Clean release of button 0.
    add(6, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    add(1, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    add(3, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // Three-cycle glitch on switch 1 is rejected.
    add(3, mk(1, 0, 2'b10, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(8, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // Three ones, a one-cycle zero, then a held one: only the last run counts.
    add(3, mk(1, 0, 2'b10, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(1, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(6, mk(1, 0, 2'b10, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(1, mk(1, 0, 2'b10, 2'b11, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
    add(2, mk(1, 0, 2'b10, 2'b11, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    add(6, mk(1, 0, 2'b00, 2'b11, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    add(1, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
    add(3, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // All four channels asserted on the same edge, then all released.
    add(6, mk(1, 0, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    add(1, mk(1, 0, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11));
    add(2, mk(1, 0, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
    add(6, mk(1, 0, 2'b00, 2'b11, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
    add(1, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11));
    add(3, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    $display("[TB] applying %0d table vectors", table_q.size());
    phase = "table";
    for (int i = 0; i < table_q.size(); i++) applyStimulus(table_q[i]);

    // Software reset: press starts 4 edges before the request and completes
    // 2 edges into the hold, so btn_o rises with no press pulse.
    phase = "sw_reset";
    run(4, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(1, mk(1, 1, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(1, mk(1, 0, 2'b00, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(2, mk(1, 0, 2'b00, 2'b10, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    run(2, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    run(6, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    run(1, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    run(2, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    // Request re-asserted mid-hold stretches the low time from 3 to 5 cycles.
    phase = "hold_extend";
    run(1, mk(1, 1, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(1, mk(1, 0, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(1, mk(1, 1, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(3, mk(1, 0, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(2, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    // Board reset while a release is two counts in: level drops, no pulse.
    phase = "mid_reset";
    run(6, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(1, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
    run(2, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    run(5, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    run(1, mk(0, 0, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(4, mk(1, 0, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(3, mk(1, 0, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // Fresh press after the reset still takes the full latency.
    run(6, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    run(1, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00));
    run(1, mk(1, 0, 2'b00, 2'b10, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
